// File: rtl/mem_pkg.sv
// Shared memory-bus definitions: command encodings, arbiter states and port indices.
package mem_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int P_CPU = 0;
  localparam int P_LDR = 1;

endpackage

// File: rtl/arb_pick.sv
// Winner selection for the two-port memory arbiter.
// policy=1 alternates on contention (the port that was not served last wins); policy=0 is fixed priority to port 0.
module arb_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       policy,
  output logic [1:0] winner
);

  always_comb begin
    winner = 2'b00;
    if (req == 2'b11)
      winner = (policy && !last) ? 2'b10 : 2'b01;
    else if (req[0])
      winner = 2'b01;
    else if (req[1])
      winner = 2'b10;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port program/data memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
//
// state  | meaning
// IDLE   | no owner; sample req and latch the winner's command
// ACCESS | command on the memory bus; reads held until the latency counter expires
// DONE   | done pulse to the owner; gnt drops on exit
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW       = 9,
  parameter int DW       = 16,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [1:0]    cmd0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic [1:0]    cmd1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic [DW-1:0] rdata,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] write_data,
  input  logic [DW-1:0] read_data
);

  localparam int CW = $clog2(READ_LAT + 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    winner;
  logic [1:0]    gnt_nx, done_nx, mem_cmd_nx;
  logic [AW-1:0] mem_addr_nx;
  logic [DW-1:0] write_data_nx, rdata_nx;
  logic [1:0]    sel_cmd;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          access_last;
  logic          last;
  logic          policy;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign policy = 1'b1;

  always_ff @(posedge clk) begin
    if (!reset)
      last <= 1'b1;
    else if (state == DONE)
      last <= gnt[P_LDR];
  end
`else
  assign policy = 1'b0;
  assign last   = 1'b1;
`endif

  arb_pick u_arb_pick (
    .req    (req),
    .last   (last),
    .policy (policy),
    .winner (winner)
  );

  assign sel_cmd   = winner[P_LDR] ? cmd1   : cmd0;
  assign sel_addr  = winner[P_LDR] ? addr1  : addr0;
  assign sel_wdata = winner[P_LDR] ? wdata1 : wdata0;

  // Writes and no-ops leave ACCESS after one cycle; reads wait for the counter.
  assign access_last = (mem_cmd != MREAD) || (cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt        <= '0;
      done       <= '0;
      rdata      <= '0;
      mem_cmd    <= MNONE;
      mem_addr   <= '0;
      write_data <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      gnt        <= gnt_nx;
      done       <= done_nx;
      rdata      <= rdata_nx;
      mem_cmd    <= mem_cmd_nx;
      mem_addr   <= mem_addr_nx;
      write_data <= write_data_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req != 2'b00) state_nx = ACCESS;
      ACCESS:  if (access_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_nx        = cnt;
    gnt_nx        = gnt;
    done_nx       = 2'b00;
    rdata_nx      = rdata;
    mem_cmd_nx    = mem_cmd;
    mem_addr_nx   = mem_addr;
    write_data_nx = write_data;
    case (state)
      IDLE: begin
        mem_cmd_nx = MNONE;
        if (req != 2'b00) begin
          gnt_nx        = winner;
          mem_cmd_nx    = (sel_cmd == MREAD || sel_cmd == MWRITE) ? sel_cmd : MNONE;
          mem_addr_nx   = sel_addr;
          write_data_nx = sel_wdata;
          cnt_nx        = (sel_cmd == MREAD) ? CW'(READ_LAT) : '0;
        end
      end
      ACCESS: begin
        if (access_last) begin
          mem_cmd_nx = MNONE;
          done_nx    = gnt;
          if (mem_cmd == MREAD)
            rdata_nx = read_data;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      DONE: begin
        gnt_nx     = 2'b00;
        mem_cmd_nx = MNONE;
      end
      default: begin
        gnt_nx     = 2'b00;
        mem_cmd_nx = MNONE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 512x16 memory (read latency 1).
module tb_mem_arbiter;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  cmd0 = '0, cmd1 = '0;
  logic [8:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic [1:0]  gnt, done, mem_cmd;
  logic [15:0] rdata, write_data, read_data;
  logic [8:0]  mem_addr;

  logic [15:0] mem [0:511];
  logic        pre_we = 1'b0;
  logic [8:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.AW(9), .DW(16), .READ_LAT(1)) dut (
    .clk(clk), .reset(reset), .req(req),
    .cmd0(cmd0), .addr0(addr0), .wdata0(wdata0),
    .cmd1(cmd1), .addr1(addr1), .wdata1(wdata1),
    .gnt(gnt), .done(done), .rdata(rdata),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .write_data(write_data),
    .read_data(read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we)
      mem[pre_addr] <= pre_data;
    else if (mem_cmd == 2'b10)
      mem[mem_addr] <= write_data;
    if (mem_cmd == 2'b01)
      read_data <= mem[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request until granted, then wait for done; lat = cycles from grant to done.
  task automatic run_txn(input int port, input logic [1:0] cmd, input logic [8:0] addr,
                         input logic [15:0] wd, output logic [1:0] done_v, output int lat);
    done_v = 2'b00;
    lat    = -1;
    if (port == 0) begin cmd0 = cmd; addr0 = addr; wdata0 = wd; end
    else begin cmd1 = cmd; addr1 = addr; wdata1 = wd; end
    req[port] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (gnt != 2'b00) break;
    end
    req = 2'b00;
    for (int i = 0; i < 20; i++) begin
      if (done != 2'b00) begin
        done_v = done;
        lat    = i;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic test_reset();
    logic [8:0]  pa [3];
    logic [15:0] pd [3];
    pa[0] = 9'h005; pd[0] = 16'hBEEF;
    pa[1] = 9'h007; pd[1] = 16'hCAFE;
    pa[2] = 9'h1FF; pd[2] = 16'h0000;
    reset = 1'b0;
    pre_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pre_addr = pa[i];
      pre_data = pd[i];
      step();
    end
    pre_we = 1'b0;
    step();
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("FAIL rst_gnt: got %h want 0", gnt); end
    n_cmp++; if (done !== 2'b00) begin n_err++; $display("FAIL rst_done: got %h want 0", done); end
    n_cmp++; if (rdata !== 16'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    n_cmp++; if (mem_cmd !== 2'b00) begin n_err++; $display("FAIL rst_mem_cmd: got %h want 0", mem_cmd); end
    n_cmp++; if (mem_addr !== 9'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (write_data !== 16'h0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", write_data); end
    reset = 1'b1;
  endtask

  task automatic test_port0_read();
    cmd0 = MREAD; addr0 = 9'h005; req = 2'b01;
    step(); req = 2'b00;
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL p0rd_gnt: got %h want 01", gnt); end
    n_cmp++; if (mem_cmd !== 2'b01) begin n_err++; $display("FAIL p0rd_cmd_c1: got %h want 01", mem_cmd); end
    n_cmp++; if (mem_addr !== 9'h005) begin n_err++; $display("FAIL p0rd_addr_c1: got %h want 005", mem_addr); end
    n_cmp++; if (done !== 2'b00) begin n_err++; $display("FAIL p0rd_done_c1: got %h want 00", done); end
    step();
    n_cmp++; if (mem_cmd !== 2'b01) begin n_err++; $display("FAIL p0rd_cmd_c2: got %h want 01", mem_cmd); end
    n_cmp++; if (mem_addr !== 9'h005) begin n_err++; $display("FAIL p0rd_addr_c2: got %h want 005", mem_addr); end
    n_cmp++; if (done !== 2'b00) begin n_err++; $display("FAIL p0rd_done_c2: got %h want 00", done); end
    step();
    n_cmp++; if (done !== 2'b01) begin n_err++; $display("FAIL p0rd_done: got %h want 01", done); end
    n_cmp++; if (rdata !== 16'hBEEF) begin n_err++; $display("FAIL p0rd_rdata: got %h want BEEF", rdata); end
    n_cmp++; if (mem_cmd !== 2'b00) begin n_err++; $display("FAIL p0rd_cmd_done: got %h want 00", mem_cmd); end
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL p0rd_gnt_done: got %h want 01", gnt); end
    step();
    n_cmp++; if (done !== 2'b00) begin n_err++; $display("FAIL p0rd_done_end: got %h want 00", done); end
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("FAIL p0rd_gnt_end: got %h want 00", gnt); end
  endtask

  task automatic test_port1_write();
    logic [1:0] dv;
    int         lat;
    cmd1 = MWRITE; addr1 = 9'h1FF; wdata1 = 16'h1234; req = 2'b10;
    step(); req = 2'b00;
    n_cmp++; if (gnt !== 2'b10) begin n_err++; $display("FAIL p1wr_gnt: got %h want 10", gnt); end
    n_cmp++; if (mem_cmd !== 2'b10) begin n_err++; $display("FAIL p1wr_cmd: got %h want 10", mem_cmd); end
    n_cmp++; if (mem_addr !== 9'h1FF) begin n_err++; $display("FAIL p1wr_addr: got %h want 1FF", mem_addr); end
    n_cmp++; if (write_data !== 16'h1234) begin n_err++; $display("FAIL p1wr_data: got %h want 1234", write_data); end
    step();
    n_cmp++; if (done !== 2'b10) begin n_err++; $display("FAIL p1wr_done: got %h want 10", done); end
    n_cmp++; if (mem_cmd !== 2'b00) begin n_err++; $display("FAIL p1wr_cmd_done: got %h want 00", mem_cmd); end
    step();
    n_cmp++; if (done !== 2'b00) begin n_err++; $display("FAIL p1wr_done_end: got %h want 00", done); end
    run_txn(0, MREAD, 9'h1FF, 16'h0, dv, lat);
    n_cmp++; if (dv !== 2'b01) begin n_err++; $display("FAIL rb_done: got %h want 01", dv); end
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL rb_latency: got %0d want 2", lat); end
    n_cmp++; if (rdata !== 16'h1234) begin n_err++; $display("FAIL rb_rdata: got %h want 1234", rdata); end
  endtask

  task automatic test_input_change();
    cmd0 = MREAD; addr0 = 9'h005; req = 2'b01;
    step();
    req = 2'b00; addr0 = 9'h007; cmd0 = MWRITE;
    n_cmp++; if (mem_addr !== 9'h005) begin n_err++; $display("FAIL chg_addr_c1: got %h want 005", mem_addr); end
    step();
    n_cmp++; if (mem_addr !== 9'h005) begin n_err++; $display("FAIL chg_addr_c2: got %h want 005", mem_addr); end
    n_cmp++; if (mem_cmd !== 2'b01) begin n_err++; $display("FAIL chg_cmd_c2: got %h want 01", mem_cmd); end
    step();
    n_cmp++; if (done !== 2'b01) begin n_err++; $display("FAIL chg_done: got %h want 01", done); end
    n_cmp++; if (rdata !== 16'hBEEF) begin n_err++; $display("FAIL chg_rdata: got %h want BEEF", rdata); end
    step();
  endtask

  task automatic test_noop();
    logic [1:0] dv;
    int         lat;
    cmd0 = 2'b11; addr0 = 9'h007; req = 2'b01;
    step(); req = 2'b00;
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL nop_gnt: got %h want 01", gnt); end
    n_cmp++; if (mem_cmd !== 2'b00) begin n_err++; $display("FAIL nop_cmd_c1: got %h want 00", mem_cmd); end
    step();
    n_cmp++; if (done !== 2'b01) begin n_err++; $display("FAIL nop_done: got %h want 01", done); end
    n_cmp++; if (mem_cmd !== 2'b00) begin n_err++; $display("FAIL nop_cmd_done: got %h want 00", mem_cmd); end
    n_cmp++; if (rdata !== 16'hBEEF) begin n_err++; $display("FAIL nop_rdata: got %h want BEEF", rdata); end
    step();
    n_cmp++; if (done !== 2'b00) begin n_err++; $display("FAIL nop_done_end: got %h want 00", done); end
    run_txn(1, MNONE, 9'h005, 16'h0, dv, lat);
    n_cmp++; if (dv !== 2'b10) begin n_err++; $display("FAIL nop00_done: got %h want 10", dv); end
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL nop00_latency: got %0d want 1", lat); end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g [4];
    logic [1:0]  g;
    logic [15:0] exp_d;
    int          got_done;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
    reset = 1'b0;
    step();
    reset = 1'b1;
    cmd0 = MREAD; addr0 = 9'h005;
    cmd1 = MREAD; addr1 = 9'h1FF;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      g = 2'b00;
      for (int i = 0; i < 20; i++) begin
        step();
        if (gnt != 2'b00) begin g = gnt; break; end
      end
      n_cmp++; if (g !== exp_g[k]) begin n_err++; $display("FAIL cont_gnt%0d: got %h want %h", k, g, exp_g[k]); end
      got_done = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (done != 2'b00) begin got_done = 1; break; end
      end
      if (k == 3) req = 2'b00;
      exp_d = exp_g[k][1] ? 16'h1234 : 16'hBEEF;
      n_cmp++; if (got_done == 0 || done !== exp_g[k]) begin n_err++; $display("FAIL cont_done%0d: got %h want %h", k, done, exp_g[k]); end
      n_cmp++; if (rdata !== exp_d) begin n_err++; $display("FAIL cont_rdata%0d: got %h want %h", k, rdata, exp_d); end
    end
    step();
    step();
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("FAIL cont_idle_gnt: got %h want 00", gnt); end
  endtask

  task automatic test_reset_mid_read();
    logic [1:0] dv;
    int         lat;
    int         pulses;
    cmd0 = MREAD; addr0 = 9'h1FF; req = 2'b01;
    step();
    req = 2'b00;
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL rmid_gnt: got %h want 01", gnt); end
    reset = 1'b0;
    step();
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("FAIL rmid_gnt_rst: got %h want 00", gnt); end
    n_cmp++; if (mem_cmd !== 2'b00) begin n_err++; $display("FAIL rmid_cmd_rst: got %h want 00", mem_cmd); end
    n_cmp++; if (rdata !== 16'h0) begin n_err++; $display("FAIL rmid_rdata_rst: got %h want 0", rdata); end
    n_cmp++; if (mem_addr !== 9'h0) begin n_err++; $display("FAIL rmid_addr_rst: got %h want 0", mem_addr); end
    pulses = (done != 2'b00) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done != 2'b00) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL rmid_no_done: got %0d pulses want 0", pulses); end
    reset = 1'b1;
    run_txn(0, MREAD, 9'h005, 16'h0, dv, lat);
    n_cmp++; if (dv !== 2'b01) begin n_err++; $display("FAIL rmid_fresh_done: got %h want 01", dv); end
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL rmid_fresh_latency: got %0d want 2", lat); end
    n_cmp++; if (rdata !== 16'hBEEF) begin n_err++; $display("FAIL rmid_fresh_rdata: got %h want BEEF", rdata); end
  endtask

  initial begin
    test_reset();
    test_port0_read();
    test_port1_write();
    test_input_change();
    test_noop();
    test_contention();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
